// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider: one quotient bit per clock, Start/Busy/Done handshake.
// A zero divisor skips iteration and reports all-ones quotient with DivByZero set.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t           state;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtraction as r_shift + ~{0,D} + 1; the extra top bit is the carry-out.
  always_comb begin
    r_shift  = {r_q, q_q[WIDTH-1]};
    trial    = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + (WIDTH + 2)'(1);
    trial_ok = trial[WIDTH+1];
    r_next   = trial_ok ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_next   = {q_q[WIDTH-2:0], trial_ok};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      d_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      count     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (Start) begin
            if (Divisor != '0) begin
              d_q       <= Divisor;
              q_q       <= Dividend;
              r_q       <= '0;
              count     <= '0;
              DivByZero <= 1'b0;
              Busy      <= 1'b1;
              state     <= StRun;
            end else begin
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              state     <= StDone;
            end
          end
        end
        StRun: begin
          q_q   <= q_next;
          r_q   <= r_next;
          count <= count + CW'(1);
          if (count == LastCount) begin
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Quotient  <= q_next;
            Remainder <= r_next;
            state     <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
